// File: rtl/flac_pkg.sv
// Shared FLAC fixed-predictor definitions: widths, decoder states, coefficient table.
package flac_pkg;

   localparam int unsigned DATA_W_DEF      = 16;
   localparam int unsigned ACC_W_DEF       = 20;
   localparam int unsigned MAX_FIXED_ORDER = 4;
   localparam int unsigned ORDER_W         = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_RUN    = 2'd2
   } dec_state_e;

   // Binomial coefficients applied to x1 (newest) .. x4 for each fixed order.
   localparam int FIXED_COEF [0:MAX_FIXED_ORDER][0:MAX_FIXED_ORDER-1] = '{
      '{ 0,  0,  0,  0},
      '{ 1,  0,  0,  0},
      '{ 2, -1,  0,  0},
      '{ 3, -3,  1,  0},
      '{ 4, -6,  4, -1}
   };

endpackage

// File: rtl/fixed_predictor.sv
// Combinational FLAC fixed predictor: (order, x1..x4) -> prediction, ACC_W wide.
module fixed_predictor
   import flac_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ACC_W  = ACC_W_DEF
) (
   input  logic        [ORDER_W-1:0] order,
   input  logic signed [DATA_W-1:0]  x1,
   input  logic signed [DATA_W-1:0]  x2,
   input  logic signed [DATA_W-1:0]  x3,
   input  logic signed [DATA_W-1:0]  x4,
   output logic signed [ACC_W-1:0]   pred
);

   logic signed [ACC_W-1:0] xe [0:MAX_FIXED_ORDER-1];

   // Constant-coefficient multiply as shift-and-add; coefficients are at most |6|.
   function automatic logic signed [ACC_W-1:0] cmul(input logic signed [ACC_W-1:0] x,
                                                    input int c);
      logic signed [ACC_W-1:0] acc;
      int mag;
      acc = '0;
      mag = (c < 0) ? -c : c;
      for (int i = 0; i < 3; i++) begin
         if (mag[i]) acc = acc + (x <<< i);
      end
      return (c < 0) ? -acc : acc;
   endfunction

   // Sign-extend history to accumulator width.
   always_comb begin
      xe[0] = ACC_W'(x1);
      xe[1] = ACC_W'(x2);
      xe[2] = ACC_W'(x3);
      xe[3] = ACC_W'(x4);
   end

   // Weighted sum of history; illegal orders predict zero.
   always_comb begin
      pred = '0;
      if (order <= ORDER_W'(MAX_FIXED_ORDER)) begin
         for (int k = 0; k < MAX_FIXED_ORDER; k++) begin
            pred = pred + cmul(xe[k], FIXED_COEF[order][k]);
         end
      end
   end

endmodule

// File: rtl/fixed_decoder.sv
// FLAC fixed-predictor decoder: residuals in, 16-bit PCM out, two-cycle latency.
module fixed_decoder
   import flac_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ACC_W  = ACC_W_DEF
) (
   input  logic                      iClock,
   input  logic                      iReset,
   input  logic                      iStart,
   input  logic        [ORDER_W-1:0] iOrder,
   input  logic                      iValid,
   input  logic signed [DATA_W-1:0]  iResidual,
   output logic signed [DATA_W-1:0]  oSample,
   output logic                      oValid,
   output logic                      oOrderError
);

   logic signed [DATA_W-1:0]  res_r;
   logic                      val_r;
   logic                      start_r;
   logic        [ORDER_W-1:0] ord_r;

   dec_state_e                state;
   logic        [ORDER_W-1:0] blk_ord;
   logic        [ORDER_W-1:0] cnt;
   logic signed [DATA_W-1:0]  x1, x2, x3, x4;

   logic signed [ACC_W-1:0]   pred_c;
   logic                      ord_bad_c;
   logic        [ORDER_W-1:0] new_ord_c;
   logic        [ORDER_W-1:0] cnt_inc_c;
   logic signed [DATA_W-1:0]  run_sample_c;

   fixed_predictor #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_pred (
      .order (blk_ord),
      .x1    (x1),
      .x2    (x2),
      .x3    (x3),
      .x4    (x4),
      .pred  (pred_c)
   );

   // Start-word order legalisation, warmup count step and wrapped reconstruction.
   always_comb begin
      ord_bad_c    = (ord_r > ORDER_W'(MAX_FIXED_ORDER));
      new_ord_c    = ord_bad_c ? '0 : ord_r;
      cnt_inc_c    = ORDER_W'(cnt + ORDER_W'(1));
      run_sample_c = DATA_W'(ACC_W'(res_r) + pred_c);
   end

   // Stage 1: register the incoming word.
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         res_r   <= '0;
         val_r   <= 1'b0;
         start_r <= 1'b0;
         ord_r   <= '0;
      end else begin
         res_r   <= iResidual;
         val_r   <= iValid;
         start_r <= iStart;
         ord_r   <= iOrder;
      end
   end

   // Stage 2: block FSM, sample reconstruction and history update.
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         state       <= ST_IDLE;
         blk_ord     <= '0;
         cnt         <= '0;
         x1          <= '0;
         x2          <= '0;
         x3          <= '0;
         x4          <= '0;
         oSample     <= '0;
         oValid      <= 1'b0;
         oOrderError <= 1'b0;
      end else if (!val_r) begin
         oValid <= 1'b0;
      end else if (start_r) begin
         // First word of a new block: a warmup sample, or a residual with zero prediction.
         blk_ord     <= new_ord_c;
         oOrderError <= ord_bad_c;
         oSample     <= res_r;
         oValid      <= 1'b1;
         {x4, x3, x2, x1} <= {x3, x2, x1, res_r};
         if (new_ord_c == '0) begin
            cnt   <= '0;
            state <= ST_RUN;
         end else begin
            cnt   <= ORDER_W'(1);
            state <= (new_ord_c == ORDER_W'(1)) ? ST_RUN : ST_WARMUP;
         end
      end else begin
         unique case (state)
            ST_WARMUP: begin
               oSample <= res_r;
               oValid  <= 1'b1;
               {x4, x3, x2, x1} <= {x3, x2, x1, res_r};
               cnt     <= cnt_inc_c;
               if (cnt_inc_c == blk_ord) state <= ST_RUN;
            end
            ST_RUN: begin
               oSample <= run_sample_c;
               oValid  <= 1'b1;
               {x4, x3, x2, x1} <= {x3, x2, x1, run_sample_c};
            end
            default: begin
               oValid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fixed_decoder.sv
// Self-checking bench for fixed_decoder: reference model plus per-cycle compare.
module tb_fixed_decoder;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ACC_W  = 20;
   localparam int unsigned N      = 1024;

   logic                     iClock = 1'b0;
   logic                     iReset;
   logic                     iStart;
   logic        [2:0]        iOrder;
   logic                     iValid;
   logic signed [DATA_W-1:0] iResidual;
   logic signed [DATA_W-1:0] oSample;
   logic                     oValid;
   logic                     oOrderError;

   fixed_decoder #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
      .iClock      (iClock),
      .iReset      (iReset),
      .iStart      (iStart),
      .iOrder      (iOrder),
      .iValid      (iValid),
      .iResidual   (iResidual),
      .oSample     (oSample),
      .oValid      (oValid),
      .oOrderError (oOrderError)
   );

   always #5 iClock = ~iClock;

   int cyc = 0;
   always @(posedge iClock) cyc <= cyc + 1;

   // Expected output per cycle index, filled by the model two cycles ahead.
   bit ev     [N];
   int es     [N];
   bit ef_set [N];
   bit ef_val [N];
   bit cur_err = 1'b0;
   bit chk_en  = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state.
   int h [4] = '{0, 0, 0, 0};
   int m_warm = 0;
   int m_ord  = 0;
   bit m_in   = 1'b0;
   bit m_err  = 1'b0;
   int coef [5][4] = '{'{0,0,0,0}, '{1,0,0,0}, '{2,-1,0,0}, '{3,-3,1,0}, '{4,-6,4,-1}};

   function automatic int wrap16(input int x);
      logic signed [15:0] t;
      t = 16'(x);
      return int'(t);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Apply one valid word; the model predicts what must emerge two cycles later.
   task automatic word(input bit st, input int ord, input int res,
                       input bit has_lit, input int lit);
      bit out;
      int s, p, idx;
      @(negedge iClock);
      iValid = 1'b1; iStart = st; iOrder = 3'(ord); iResidual = 16'(res);
      idx = cyc + 2;
      out = 1'b0;
      s   = 0;
      if (st) begin
         m_ord  = (ord > 4) ? 0 : ord;
         m_err  = (ord > 4);
         m_warm = m_ord;
         m_in   = 1'b1;
         ef_set[idx] = 1'b1;
         ef_val[idx] = m_err;
      end
      if (m_in) begin
         out = 1'b1;
         if (m_warm > 0) begin
            s = wrap16(res);
            m_warm--;
         end else begin
            p = 0;
            for (int k = 0; k < 4; k++) p += coef[m_ord][k] * h[k];
            s = wrap16(res + p);
         end
         h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = s;
      end
      if (out) begin
         ev[idx] = 1'b1;
         es[idx] = s;
      end
      if (has_lit) check("model_literal", out ? s : 99999, lit);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge iClock);
         iValid = 1'b0; iStart = 1'b0;
      end
   endtask

   // Per-cycle compare against the model's expectations.
   always @(negedge iClock) begin
      if (chk_en && cyc < N) begin
         if (ef_set[cyc]) cur_err = ef_val[cyc];
         check("valid", int'(oValid), int'(ev[cyc]));
         if (ev[cyc]) check("sample", int'(oSample), es[cyc]);
         check("order_err", int'(oOrderError), int'(cur_err));
      end
   end

   initial begin
      iReset = 1'b0; iStart = 1'b0; iOrder = '0; iValid = 1'b0; iResidual = '0;
      #2;
      check("rst_sample", int'(oSample), 0);
      check("rst_valid", int'(oValid), 0);
      check("rst_err", int'(oOrderError), 0);
      @(negedge iClock);
      @(negedge iClock);
      iReset = 1'b1;
      chk_en = 1'b1;
      idle(2);

      // Order 0 pass-through
      word(1, 0, 7, 1, 7);
      word(0, 0, -3, 1, -3);
      word(0, 0, 32767, 1, 32767);
      idle(2);

      // Order 1
      word(1, 1, 100, 1, 100);
      word(0, 0, 5, 1, 105);
      word(0, 0, -3, 1, 102);
      word(0, 0, 0, 1, 102);

      // Order 2, then order 4
      word(1, 2, 10, 1, 10);
      word(0, 0, 20, 1, 20);
      word(0, 0, 0, 1, 30);
      word(0, 0, 0, 1, 40);
      word(0, 0, 1, 1, 51);
      word(1, 4, 1, 1, 1);
      word(0, 0, 2, 1, 2);
      word(0, 0, 3, 1, 3);
      word(0, 0, 4, 1, 4);
      word(0, 0, 0, 1, 5);

      // Two's-complement wrap both ways
      word(1, 1, 32767, 1, 32767);
      word(0, 0, 1, 1, -32768);
      word(0, 0, -1, 1, 32767);
      idle(1);

      // Bubbles, then a restart mid-stream
      word(1, 1, 50, 1, 50);
      idle(3);
      word(0, 0, 2, 1, 52);
      idle(3);
      word(1, 2, 1, 1, 1);
      word(0, 0, 1, 1, 1);
      word(0, 0, 0, 1, 1);
      idle(3);

      // Illegal order: flagged, words pass through unmodified
      word(1, 6, 11, 1, 11);
      word(0, 0, 12, 1, 12);
      word(0, 0, -5, 1, -5);
      idle(3);
      check("err_sticky", int'(oOrderError), 1);

      // Legal start clears the flag; then reset with a word in flight
      word(1, 1, 40, 1, 40);
      word(0, 0, 2, 1, 42);
      word(0, 0, 9, 0, 0);
      @(posedge iClock);
      #3;
      iReset = 1'b0;
      iValid = 1'b0; iStart = 1'b0;
      for (int i = cyc; i < N; i++) begin
         ev[i] = 1'b0;
         ef_set[i] = 1'b0;
      end
      ef_set[cyc] = 1'b1;
      ef_val[cyc] = 1'b0;
      h = '{0, 0, 0, 0};
      m_in = 1'b0; m_err = 1'b0; m_warm = 0; m_ord = 0;
      #1;
      check("mid_rst_sample", int'(oSample), 0);
      check("mid_rst_valid", int'(oValid), 0);
      check("mid_rst_err", int'(oOrderError), 0);
      @(negedge iClock);
      iReset = 1'b1;
      idle(2);

      // Word without a start after reset is dropped
      word(0, 1, 123, 1, 99999);
      idle(3);
      check("drop_valid", int'(oValid), 0);
      check("drop_sample", int'(oSample), 0);
      idle(3);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
